// File: rtl/bit_pattern_detector.sv
// bit_pattern_detector
//   Serial pattern matcher. Accepted bits (bit_valid = 1) shift into a
//   PAT_LEN-bit history, MSB = oldest bit. A one-cycle registered match pulse
//   is raised once at least PAT_LEN bits have been seen and the history equals
//   PATTERN. With OVERLAP = 0 the history and fill are dropped after a match.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bit_in       serial data bit
//   bit_valid    qualifies bit_in
//   clear        synchronous clear of history, fill and match_count
//   match        one-cycle pulse, the cycle after the completing bit
//   match_count  saturating count of matches since reset/clear
//   hist         current history register (debug)
module bit_pattern_detector #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [PAT_LEN-1:0] hist
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] hist_shift_c;
  logic [FILL_W-1:0]  fill_inc_c;
  logic               hit_c;

  // Candidate next history/fill and match decision for an accepted bit.
  // Fill gating keeps an all-zero pattern from matching reset-zeroed history.
  always_comb begin
    hist_shift_c = {hist[PAT_LEN-2:0], bit_in};
    fill_inc_c   = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);
    hit_c        = bit_valid && !clear &&
                   (fill_inc_c == FILL_W'(PAT_LEN)) &&
                   (hist_shift_c == PATTERN);
  end

  // History, fill, match pulse and saturating match counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= hit_c;
      if (bit_valid) begin
        if (hit_c && !OVERLAP) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= hist_shift_c;
          fill <= fill_inc_c;
        end
        if (hit_c && (match_count != '1)) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_pattern_detector.sv
// Bench for bit_pattern_detector: three instances (default, non-overlapping,
// 2-bit counter) driven by one stimulus stream and checked every cycle
// against a queue-based model of the accepted bit stream.
module tb_bit_pattern_detector;

  localparam logic [3:0] PAT = 4'b1011;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       clear;

  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [3:0] hist_a, hist_b, hist_c;

  int tests = 0;
  int fails = 0;

  // Model state: accepted bits since last discard, per instance.
  bit q_a[$];
  bit q_b[$];
  bit q_c[$];
  int exp_cnt[3];
  bit exp_m[3];

  bit_pattern_detector dut_a (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .match(match_a), .match_count(cnt_a), .hist(hist_a)
  );

  bit_pattern_detector #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .match(match_b), .match_count(cnt_b), .hist(hist_b)
  );

  bit_pattern_detector #(.CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .match(match_c), .match_count(cnt_c), .hist(hist_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Most recent (up to) four accepted bits, oldest in the MSB, zeros if fewer.
  function automatic logic [3:0] tail4(input bit q[$]);
    logic [3:0] r;
    int n;
    r = '0;
    n = q.size();
    for (int i = 0; i < n; i++) r[n-1-i] = q[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(ref bit q[$], input bit b, input bit ovl,
                              input int cmax, inout int cnt, output bit m);
    q.push_back(b);
    if (q.size() > 4) void'(q.pop_front());
    m = (q.size() == 4) && (tail4(q) == PAT);
    if (m) begin
      if (cnt < cmax) cnt++;
      if (!ovl) q.delete();
    end
  endtask

  task automatic model_zero();
    q_a.delete(); q_b.delete(); q_c.delete();
    for (int i = 0; i < 3; i++) begin
      exp_cnt[i] = 0;
      exp_m[i]   = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("a_match", 16'(match_a), 16'(exp_m[0]));
    chk("a_hist",  16'(hist_a),  16'(tail4(q_a)));
    chk("a_count", 16'(cnt_a),   16'(exp_cnt[0]));
    chk("b_match", 16'(match_b), 16'(exp_m[1]));
    chk("b_hist",  16'(hist_b),  16'(tail4(q_b)));
    chk("b_count", 16'(cnt_b),   16'(exp_cnt[1]));
    chk("c_match", 16'(match_c), 16'(exp_m[2]));
    chk("c_hist",  16'(hist_c),  16'(tail4(q_c)));
    chk("c_count", 16'(cnt_c),   16'(exp_cnt[2]));
  endtask

  // Apply one cycle of stimulus, step the model, check 1 time unit after the edge.
  task automatic cycle(input bit v, input bit b, input bit clr);
    bit_valid = v;
    bit_in    = b;
    clear     = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      model_zero();
    end else if (v) begin
      model_accept(q_a, b, 1'b1, 255, exp_cnt[0], exp_m[0]);
      model_accept(q_b, b, 1'b0, 255, exp_cnt[1], exp_m[1]);
      model_accept(q_c, b, 1'b1, 3,   exp_cnt[2], exp_m[2]);
    end else begin
      for (int i = 0; i < 3; i++) exp_m[i] = 1'b0;
    end
    check_all();
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0);
  endtask

  initial begin
    logic [15:0] s;
    reset     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear     = 1'b0;
    model_zero();

    // Reset state, with inputs active while reset is held.
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();

    // Release reset; the very next edge accepts a bit.
    reset = 1'b1;
    bit_valid = 1'b0;

    // Basic match: 1,0,1,1 back to back.
    s = 16'b1011;
    send(s, 4);
    chk("basic_match", 16'(match_a), 16'd1);
    chk("basic_hist",  16'(hist_a),  16'b1011);
    chk("basic_count", 16'(cnt_a),   16'd1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("pulse_one_cycle", 16'(match_a), 16'd0);

    // Overlap vs non-overlap on 1,0,1,1,0,1,1.
    cycle(1'b0, 1'b0, 1'b1);
    s = 16'b1011011;
    send(s, 7);
    chk("ovl_count",    16'(cnt_a),  16'd2);
    chk("noovl_count",  16'(cnt_b),  16'd1);
    chk("noovl_hist",   16'(hist_b), 16'b0011);
    chk("noovl_fill",   16'(dut_b.fill), 16'd3);

    // Gap in bit_valid holds history.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'($urandom), 1'b0);
      chk("gap_hist", 16'(hist_a), 16'b0010);
    end
    cycle(1'b1, 1'b1, 1'b0);
    chk("gap_nomatch_yet", 16'(match_a), 16'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("gap_match", 16'(match_a), 16'd1);

    // Mid-pattern asynchronous reset pulse of 7 time units between edges.
    cycle(1'b0, 1'b0, 1'b1);
    s = 16'b101;
    send(s, 3);
    reset = 1'b0;
    #3;
    model_zero();
    check_all();
    #4;
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    chk("rst_hist",  16'(hist_a),  16'b0001);
    chk("rst_match", 16'(match_a), 16'd0);

    // Counter saturation with a 2-bit counter: five matches.
    cycle(1'b0, 1'b0, 1'b1);
    s = 16'b1011;
    for (int k = 0; k < 5; k++) send(s, 4);
    chk("sat_c_count", 16'(cnt_c), 16'd3);
    chk("sat_a_count", 16'(cnt_a), 16'd5);

    // Clear wins over a valid bit, even one that would complete a match.
    s = 16'b101;
    send(s, 3);
    cycle(1'b1, 1'b1, 1'b1);
    chk("clr_match", 16'(match_a), 16'd0);
    chk("clr_hist",  16'(hist_a),  16'd0);
    chk("clr_count", 16'(cnt_c),   16'd0);

    // Randomized stream with occasional gaps and clears.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_pattern_detector.md
BIT_PATTERN_DETECTOR -- requirements
Module: bit_pattern_detector

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: target pattern; bit PAT_LEN-1 is matched against the oldest received bit.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed; 0 = history is discarded after each match.
REQ-004 Parameter CNT_W, default 8: width of match_count.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous active-low reset (0 = reset asserted).
REQ-007 Port bit_in, input, 1: serial data bit from the upstream registered D-flip-flop stage.
REQ-008 Port bit_valid, input, 1: bit_in is sampled only in cycles where bit_valid = 1.
REQ-009 Port clear, input, 1: synchronous clear of history, fill count and match_count.
REQ-010 Port match, output, 1: one-cycle pulse, registered, when the pattern completes.
REQ-011 Port match_count, output, CNT_W: number of matches since reset or clear; saturates.
REQ-012 Port hist, output, PAT_LEN: current shift-history register, for debug.

Function
REQ-013 On each rising clk with bit_valid = 1 and clear = 0, hist shall shift left with bit_in entering bit 0.
REQ-014 When bit_valid = 0, hist, fill and match_count shall hold and match shall be 0 in the next cycle.
REQ-015 An internal fill counter shall count accepted bits, saturating at PAT_LEN.
REQ-016 A match shall be declared for the edge that accepts a bit only if fill (including that bit) equals PAT_LEN and the shifted history equals PATTERN.
REQ-017 match shall be asserted for exactly the one cycle following the accepting edge (latency 1 clk from bit acceptance).
REQ-018 With OVERLAP = 1, fill shall remain at PAT_LEN after a match, so a suffix/prefix overlap can produce a further match.
REQ-019 With OVERLAP = 0, a match shall reset fill to 0 and hist to all-zeros on the same edge; the next match needs PAT_LEN new bits.
REQ-020 match_count shall increment by 1 on each declared match and hold at 2^CNT_W - 1 without wrapping.
REQ-021 clear = 1 shall take priority over bit_valid: on that edge hist, fill and match_count go to 0, match goes to 0, and bit_in is discarded.
REQ-022 A pattern of all zeros shall not match on reset-zeroed history; the fill gating in REQ-016 enforces this.
REQ-023 Back-to-back valid bits on consecutive cycles shall be accepted without bubbles (throughput of 1 bit/clk).

Reset
REQ-024 While reset = 0 (asynchronous, no clk required), hist = 0, fill = 0, match = 0 and match_count = 0.
REQ-025 Deassertion of reset shall take effect at the next rising clk; a bit presented on that edge shall be accepted.
REQ-026 Reset asserted mid-pattern shall discard the partial history; no match shall result from pre-reset bits.

Verification
REQ-027 Default parameters, valid bits 1,0,1,1 on consecutive cycles -> match = 1 for one cycle after the 4th bit; match_count = 1; hist = 4'b1011.
REQ-028 OVERLAP = 1, stream 1,0,1,1,0,1,1 -> two match pulses (after bits 4 and 7); match_count = 2.
REQ-029 OVERLAP = 0, same stream -> one match after bit 4 only; match_count = 1; fill = 3 at the end.
REQ-030 Stream 1,0,(bit_valid = 0 for 3 cycles),1,1 -> hist holds during the gap; single match after the final bit.
REQ-031 Stream 1,0,1, then reset pulled low for 7 ns between edges, then bit 1 -> match stays 0 and hist = 4'b0001.
REQ-032 CNT_W = 2, five matches -> match_count saturates at 3; clear = 1 together with bit_valid = 1 -> all state 0 and no match.
